// File: rtl/lsu.sv
// RV32I load/store unit: one access at a time over a req/ack data-memory port.
// Aligns and extends load data and flags misaligned, illegal and timed-out accesses.
module lsu #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   input  logic        req_store,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          store_q, store_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [4:0]    rrd_q, rrd_d;
   logic          err_q, err_d;

   logic          legal;
   logic          misaligned;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata;
   logic [31:0]   shifted;
   logic [31:0]   load_ext;

   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      lane_be    = 4'hF;
      lane_wdata = req_wdata;
      if (req_store) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else           legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                          || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
      case (req_funct3[1:0])
         2'b00: begin
            lane_be    = 4'b0001 << req_addr[1:0];
            lane_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            lane_be    = 4'b0011 << req_addr[1:0];
            lane_wdata = {2{req_wdata[15:0]}};
            misaligned = req_addr[0];
         end
         default: begin
            misaligned = (req_addr[1:0] != 2'b00);
         end
      endcase
   end

   always_comb begin
      shifted  = mem_rdata >> {off_q, 3'b000};
      load_ext = shifted;
      case (f3_q)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {24'h000000, shifted[7:0]};
         3'b101:  load_ext = {16'h0000, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      store_d = store_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      rrd_d   = rrd_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (legal && !misaligned) begin
                  state_d = S_BUS;
                  cnt_d   = '0;
                  store_d = req_store;
                  f3_d    = req_funct3;
                  off_d   = req_addr[1:0];
                  rd_d    = req_rd;
                  addr_d  = {req_addr[31:2], 2'b00};
                  wdata_d = lane_wdata;
                  be_d    = lane_be;
               end else begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
                  rrd_d   = '0;
               end
            end
         end
         S_BUS: begin
            // ack is checked first so it wins over a timeout in the same cycle
            if (mem_ack) begin
               state_d = S_RESP;
               err_d   = 1'b0;
               rdata_d = store_q ? '0 : load_ext;
               rrd_d   = store_q ? '0 : rd_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_RESP;
               err_d   = 1'b1;
               rdata_d = '0;
               rrd_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            rdata_d = '0;
            rrd_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         store_q <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         rd_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         rrd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         rrd_q   <= rrd_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = err_q;
   assign resp_data  = rdata_q;
   assign resp_rd    = rrd_q;
   assign mem_req    = (state_q == S_BUS);
   assign mem_we     = mem_req & store_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_be     = be_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a byte-level reference model supplies per-cycle
// expectations and a negedge compare process checks every output against them.
module tb_lsu;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_store = 1'b0;
   logic [4:0]  req_rd = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   lsu #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_funct3(req_funct3), .req_store(req_store), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // reference model
   function automatic int m_size(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit code_ok;
      if (st) code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      return code_ok && ((int'(a[1:0]) % m_size(f3)) == 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] be = '0;
      for (int i = 0; i < m_size(f3); i++) be[int'(a[1:0]) + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % m_size(f3)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v = '0;
      int n = m_size(f3);
      int off = int'(a[1:0]);
      for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!f3[2] && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   // per-cycle expectations
   bit          chk_en = 1'b0;
   logic        e_rv, e_err, e_mreq, e_mwe, e_busy;
   logic [31:0] e_rdata, e_maddr, e_mwd;
   logic [4:0]  e_rrd;
   logic [3:0]  e_be;

   task automatic set_idle();
      e_rv = 0; e_err = 0; e_rdata = '0; e_rrd = '0;
      e_mreq = 0; e_mwe = 0; e_busy = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("resp_valid", resp_valid, e_rv);
         chk("resp_err", resp_err, e_err);
         chk("resp_data", resp_data, e_rdata);
         chk("resp_rd", resp_rd, e_rrd);
         chk("mem_req", mem_req, e_mreq);
         chk("mem_we", mem_we, e_mwe);
         chk("busy", busy, e_busy);
         chk("req_ready", req_ready, !e_busy);
         if (e_mreq) begin
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_be", mem_be, e_be);
            chk("mem_wdata", mem_wdata, e_mwd);
         end
      end
   end

   task automatic chk_reset_state();
      @(negedge clk);
      chk("rst.resp_valid", resp_valid, 0);
      chk("rst.resp_err", resp_err, 0);
      chk("rst.resp_data", resp_data, 0);
      chk("rst.resp_rd", resp_rd, 0);
      chk("rst.mem_req", mem_req, 0);
      chk("rst.mem_we", mem_we, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.mem_be", mem_be, 0);
      chk("rst.busy", busy, 0);
      chk("rst.req_ready", req_ready, 1);
   endtask

   logic [31:0] g_data, g_wd;
   logic        g_err;
   logic [4:0]  g_rd;
   logic [3:0]  g_be;
   int          g_reqcyc;

   // ack_at: BUS cycle index carrying mem_ack, or -1 for none
   task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [4:0] rd, input int ack_at,
                            input logic [31:0] rdat, input bit keep);
      bit ok = m_legal(st, f3, a);
      bit acked = 0;
      set_idle();
      req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
      @(posedge clk); #1;
      if (keep) begin
         req_addr = ~a; req_wdata = ~wd; req_rd = ~rd;
      end else req_valid = 0;
      g_reqcyc = 0; g_be = '0; g_wd = '0;
      if (ok) begin
         for (int k = 0; k < TO; k++) begin
            e_mreq = 1; e_mwe = st; e_busy = 1;
            e_maddr = {a[31:2], 2'b00}; e_be = m_be(f3, a); e_mwd = m_wd(f3, wd);
            mem_ack = (k == ack_at); mem_rdata = rdat;
            @(negedge clk);
            g_reqcyc += int'(mem_req); g_be = mem_be; g_wd = mem_wdata;
            @(posedge clk); #1;
            mem_ack = 0;
            if (k == ack_at) begin
               acked = 1;
               break;
            end
         end
         e_err = !acked;
         e_rdata = (acked && !st) ? m_load(f3, a, rdat) : '0;
         e_rrd = (acked && !st) ? rd : '0;
      end else begin
         e_err = 1; e_rdata = '0; e_rrd = '0;
      end
      e_rv = 1; e_mreq = 0; e_mwe = 0; e_busy = 1;
      req_valid = 0;
      @(negedge clk);
      g_data = resp_data; g_err = resp_err; g_rd = resp_rd;
      @(posedge clk); #1;
      set_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle();
      e_maddr = '0; e_be = '0; e_mwd = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state();
      @(posedge clk); #1;
      rst = 0;
      chk_en = 1;

      // model pins
      chk("pin.lb", m_load(3'd0, 32'h103, 32'h80FF_FF7F), 32'hFFFF_FF80);
      chk("pin.sh_be", m_be(3'd1, 32'h202), 4'b1100);
      chk("pin.sh_wd", m_wd(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);

      do_access(0, 3'b010, 32'h100, 0, 5'd5, 0, 32'hDEAD_BEEF, 0);
      chk("lw.data", g_data, 32'hDEAD_BEEF);
      chk("lw.rd", g_rd, 5);
      chk("lw.be", g_be, 4'hF);
      chk("lw.reqcyc", g_reqcyc, 1);

      do_access(0, 3'b000, 32'h103, 0, 5'd9, 0, 32'h80FF_FF7F, 0);
      chk("lb.data", g_data, 32'hFFFF_FF80);
      do_access(0, 3'b100, 32'h103, 0, 5'd9, 1, 32'h80FF_FF7F, 0);
      chk("lbu.data", g_data, 32'h0000_0080);
      do_access(0, 3'b101, 32'h102, 0, 5'd10, 0, 32'h80FF_FF7F, 0);
      chk("lhu.data", g_data, 32'h0000_80FF);
      do_access(0, 3'b001, 32'h102, 0, 5'd11, 0, 32'h80FF_FF7F, 1);
      chk("lh.data", g_data, 32'hFFFF_80FF);

      do_access(1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 2, 32'h5555_5555, 1);
      chk("sh.be", g_be, 4'b1100);
      chk("sh.wd", g_wd, 32'hABCD_ABCD);
      chk("sh.rd", g_rd, 0);
      chk("sh.err", g_err, 0);
      chk("sh.data", g_data, 0);
      do_access(1, 3'b000, 32'h301, 32'h0000_00A5, 5'd3, 0, 0, 0);
      chk("sb.be", g_be, 4'b0010);
      chk("sb.wd", g_wd, 32'hA5A5_A5A5);
      do_access(1, 3'b010, 32'h304, 32'hCAFE_F00D, 5'd3, 3, 0, 0);
      chk("sw.wd", g_wd, 32'hCAFE_F00D);

      do_access(0, 3'b010, 32'h101, 0, 5'd7, 0, 32'h1111_1111, 0);
      chk("mis.err", g_err, 1);
      chk("mis.data", g_data, 0);
      chk("mis.reqcyc", g_reqcyc, 0);
      do_access(0, 3'b011, 32'h100, 0, 5'd7, 0, 0, 0);
      chk("ill.err", g_err, 1);
      chk("ill.rd", g_rd, 0);
      do_access(1, 3'b100, 32'h100, 32'h1, 5'd7, 0, 0, 0);
      chk("ill_st.err", g_err, 1);
      do_access(1, 3'b001, 32'h103, 32'h1, 5'd7, 0, 0, 0);
      chk("mis_sh.err", g_err, 1);

      do_access(0, 3'b010, 32'h400, 0, 5'd12, -1, 0, 0);
      chk("to.err", g_err, 1);
      chk("to.reqcyc", g_reqcyc, TO);
      chk("to.rd", g_rd, 0);
      set_idle();
      mem_ack = 1; mem_rdata = 32'h7777_7777;
      repeat (2) @(posedge clk);
      #1 mem_ack = 0;

      do_access(0, 3'b010, 32'h404, 0, 5'd13, TO - 1, 32'h0BAD_F00D, 0);
      chk("to_ack.err", g_err, 0);
      chk("to_ack.data", g_data, 32'h0BAD_F00D);

      // reset in the middle of a bus access
      set_idle();
      req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h40; req_rd = 5'd7;
      @(posedge clk); #1;
      req_valid = 0;
      e_mreq = 1; e_mwe = 0; e_busy = 1; e_maddr = 32'h40; e_be = 4'hF; e_mwd = '0;
      @(posedge clk); #1;
      rst = 1; mem_ack = 1; mem_rdata = 32'h9999_9999;
      @(posedge clk); #1;
      set_idle();
      chk_reset_state();
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      mem_ack = 0;
      do_access(0, 3'b010, 32'h0, 0, 5'd1, 0, 32'h1357_9BDF, 0);
      chk("post_rst.data", g_data, 32'h1357_9BDF);
      chk("post_rst.rd", g_rd, 1);

      repeat (2) @(posedge clk);
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
